// File: rtl/sudoku_pkg.sv
// Shared types for the sudoku entry path.
// Cell count, digit type and collector state encoding.
package sudoku_pkg;

  localparam int NUM_CELLS = 9;

  typedef logic [3:0] digit_t;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } collector_state_t;

endpackage

// File: rtl/digit_collector.sv
// Loads nine digits in arrival order and holds the full grid until acked.
// Optional DIGIT_DELETE_EN adds a digit_del port that backs out the last digit.
module digit_collector
  import sudoku_pkg::*;
(
  input  logic       clock,
  input  logic       reset_L,
  input  logic [3:0] digit_in,
  input  logic       digit_valid,
  output logic       digit_ready,
  input  logic       clear,
  input  logic       grid_ack,
`ifdef DIGIT_DELETE_EN
  input  logic       digit_del,
`endif
  output logic [3:0] num1,
  output logic [3:0] num2,
  output logic [3:0] num3,
  output logic [3:0] num4,
  output logic [3:0] num5,
  output logic [3:0] num6,
  output logic [3:0] num7,
  output logic [3:0] num8,
  output logic [3:0] num9,
  output logic [3:0] count,
  output logic       grid_full
);

  collector_state_t state_q, state_d;
  logic [3:0]       count_q, count_d;
  digit_t           cells_q [NUM_CELLS];
  digit_t           cells_d [NUM_CELLS];
  logic             del;
  logic             accept;

`ifdef DIGIT_DELETE_EN
  assign del = digit_del;
`else
  assign del = 1'b0;
`endif

  assign digit_ready = (state_q == FILL) && !del;
  assign grid_full   = (state_q == FULL);
  assign accept      = digit_valid && digit_ready;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    cells_d = cells_q;
    if (clear) begin
      state_d = FILL;
      count_d = 4'd0;
      for (int i = 0; i < NUM_CELLS; i++) cells_d[i] = '0;
    end else if (state_q == FULL) begin
      if (grid_ack) begin
        state_d = FILL;
        count_d = 4'd0;
        for (int i = 0; i < NUM_CELLS; i++) cells_d[i] = '0;
      end
    end else if (del) begin
      if (count_q != 4'd0) begin
        for (int i = 0; i < NUM_CELLS; i++)
          if (4'(i) == count_q - 4'd1) cells_d[i] = '0;
        count_d = count_q - 4'd1;
      end
    end else if (accept) begin
      // count_q is at most NUM_CELLS-1 while filling
      for (int i = 0; i < NUM_CELLS; i++)
        if (4'(i) == count_q) cells_d[i] = digit_in;
      count_d = count_q + 4'd1;
      if (count_q == 4'(NUM_CELLS - 1)) state_d = FULL;
    end
  end

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      state_q <= FILL;
      count_q <= 4'd0;
      for (int i = 0; i < NUM_CELLS; i++) cells_q[i] <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      cells_q <= cells_d;
    end
  end

  assign count = count_q;
  assign num1  = cells_q[0];
  assign num2  = cells_q[1];
  assign num3  = cells_q[2];
  assign num4  = cells_q[3];
  assign num5  = cells_q[4];
  assign num6  = cells_q[5];
  assign num7  = cells_q[6];
  assign num8  = cells_q[7];
  assign num9  = cells_q[8];

endmodule

// File: tb/tb_digit_collector.sv
// Bench for digit_collector: directed scenarios plus random traffic
// compared against a queue-based model of the collected grid.
module tb_digit_collector;
  import sudoku_pkg::*;

  logic       clock;
  logic       reset_L;
  logic [3:0] digit_in;
  logic       digit_valid;
  logic       digit_ready;
  logic       clear;
  logic       grid_ack;
  logic       dl;
  logic [3:0] num1, num2, num3, num4, num5;
  logic [3:0] num6, num7, num8, num9;
  logic [3:0] count;
  logic       grid_full;

  int checks = 0;
  int errors = 0;

  logic [3:0] mq[$];
  logic       mfull;

  digit_collector dut (
    .clock       (clock),
    .reset_L     (reset_L),
    .digit_in    (digit_in),
    .digit_valid (digit_valid),
    .digit_ready (digit_ready),
    .clear       (clear),
    .grid_ack    (grid_ack),
`ifdef DIGIT_DELETE_EN
    .digit_del   (dl),
`endif
    .num1        (num1),
    .num2        (num2),
    .num3        (num3),
    .num4        (num4),
    .num5        (num5),
    .num6        (num6),
    .num7        (num7),
    .num8        (num8),
    .num9        (num9),
    .count       (count),
    .grid_full   (grid_full)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag,
                       input logic [35:0] got,
                       input logic [35:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [35:0] exp_cells();
    logic [35:0] v = '0;
    for (int i = 0; i < mq.size(); i++) v[i*4 +: 4] = mq[i];
    return v;
  endfunction

  task automatic check_state(input string tag);
    check({tag, ".count"}, 36'(count), 36'(mq.size()));
    check({tag, ".full"}, 36'(grid_full), 36'(mfull));
    check({tag, ".cells"},
          {num9, num8, num7, num6, num5, num4, num3, num2, num1},
          exp_cells());
  endtask

  task automatic model_reset();
    mq.delete();
    mfull = 1'b0;
  endtask

  task automatic model_edge(input logic v, input logic [3:0] d,
                            input logic clr, input logic ack,
                            input logic del);
    if (clr) model_reset();
    else if (mfull) begin
      if (ack) model_reset();
    end else if (del) begin
      if (mq.size() > 0) void'(mq.pop_back());
    end else if (v) begin
      mq.push_back(d);
      if (mq.size() == 9) mfull = 1'b1;
    end
  endtask

  // Called at a negedge: drive inputs, check ready, clock once, check state.
  task automatic step(input string tag, input logic v,
                      input logic [3:0] d, input logic clr,
                      input logic ack, input logic del);
    digit_valid = v;
    digit_in    = d;
    clear       = clr;
    grid_ack    = ack;
    dl          = del;
    #1;
    check({tag, ".ready"}, 36'(digit_ready), 36'(!mfull && !del));
    @(posedge clock);
    model_edge(v, d, clr, ack, del);
    @(negedge clock);
    digit_valid = 1'b0;
    clear       = 1'b0;
    grid_ack    = 1'b0;
    dl          = 1'b0;
    check_state(tag);
  endtask

  initial begin
    logic del_r;
    reset_L     = 1'b0;
    digit_in    = 4'd0;
    digit_valid = 1'b0;
    clear       = 1'b0;
    grid_ack    = 1'b0;
    dl          = 1'b0;
    model_reset();
    #12;
    check_state("reset");
    check("reset.ready", 36'(digit_ready), 36'd1);
    reset_L = 1'b1;
    @(negedge clock);

    for (int i = 1; i <= 9; i++) step("fill", 1'b1, 4'(i), 1'b0, 1'b0, 1'b0);
    check("fill.num9", 36'(num9), 36'd9);
    check("fill.gfull", 36'(grid_full), 36'd1);

    step("full_hold", 1'b1, 4'd5, 1'b0, 1'b0, 1'b0);
    step("ack", 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    check("ack.ready", 36'(digit_ready), 36'd1);

    for (int i = 0; i < 4; i++) step("pre_clr", 1'b1, 4'(i + 2), 1'b0, 1'b0, 1'b0);
    step("clear", 1'b1, 4'd7, 1'b1, 1'b0, 1'b0);
    check("clear.num1", 36'(num1), 36'd0);

    step("raw3", 1'b1, 4'd3, 1'b0, 1'b0, 1'b0);
    step("raw10", 1'b1, 4'd10, 1'b0, 1'b0, 1'b0);
    step("raw0", 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
    check("raw.num2", 36'(num2), 36'd10);

    for (int i = 0; i < 3; i++) step("pre_rst", 1'b1, 4'(i + 11), 1'b0, 1'b0, 1'b0);
    check("pre_rst.count", 36'(count), 36'd6);
    #2;
    reset_L = 1'b0;
    #1;
    model_reset();
    check_state("async_rst");
    @(negedge clock);
    #2;
    reset_L = 1'b1;
    @(negedge clock);
    step("post_rst", 1'b1, 4'd8, 1'b0, 1'b0, 1'b0);
    check("post_rst.num1", 36'(num1), 36'd8);
    step("clr2", 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);

`ifdef DIGIT_DELETE_EN
    step("d2", 1'b1, 4'd2, 1'b0, 1'b0, 1'b0);
    step("d4", 1'b1, 4'd4, 1'b0, 1'b0, 1'b0);
    step("d6", 1'b1, 4'd6, 1'b0, 1'b0, 1'b0);
    step("del", 1'b1, 4'd8, 1'b0, 1'b0, 1'b1);
    check("del.num3", 36'(num3), 36'd0);
    step("d9", 1'b1, 4'd9, 1'b0, 1'b0, 1'b0);
    check("d9.num3", 36'(num3), 36'd9);
    step("clr3", 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    step("del_empty", 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
`endif

    for (int n = 0; n < 400; n++) begin
`ifdef DIGIT_DELETE_EN
      del_r = ($urandom_range(0, 9) == 0);
`else
      del_r = 1'b0;
`endif
      step("rand",
           ($urandom_range(0, 9) < 7),
           4'($urandom_range(0, 15)),
           ($urandom_range(0, 29) == 0),
           ($urandom_range(0, 3) == 0),
           del_r);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
